// File: rtl/wbaq_store_drain.sv
// wbaq_store_drain: write-back address queue between writeback and the D$ write port.
//   Accepts one committed store per cycle (mem_ld/mem_addr/mem_data/memsize), pushes
//   back with wbaq_full, and drains in order as 16-byte-line byte-masked requests on a
//   valid/ready handshake. A store crossing a line boundary goes out as two requests.
// Ports:
//   clk, rst (sync, active high)
//   mem_ld, mem_addr[31:0], mem_data[63:0], memsize[1:0]  - enqueue side
//   wbaq_full, wbaq_empty                                  - decoded from registered count
//   dc_req_valid/ready, dc_req_line[27:0], dc_req_mask[15:0], dc_req_data[127:0]
//   ld_chk_addr[31:0], ld_conflict                         - line conflict probe
// Optional feature: define WBAQ_LD_CONFLICT_EN to build the load/store line comparators;
// otherwise ld_conflict is tied low.
module wbaq_store_drain #(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_ld,
    input  logic [31:0]  mem_addr,
    input  logic [63:0]  mem_data,
    input  logic [1:0]   memsize,
    output logic         wbaq_full,
    output logic         wbaq_empty,
    output logic         dc_req_valid,
    input  logic         dc_req_ready,
    output logic [27:0]  dc_req_line,
    output logic [15:0]  dc_req_mask,
    output logic [127:0] dc_req_data,
    input  logic [31:0]  ld_chk_addr,
    output logic         ld_conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_e;

    logic [31:0]   addr_q [DEPTH];
    logic [31:0]   addr_d [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [63:0]   data_d [DEPTH];
    logic [1:0]    size_q [DEPTH];
    logic [1:0]    size_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    state_e        state_q, state_d;

    logic          push, pop;
    logic [31:0]   h_addr;
    logic [63:0]   h_data, h_dm;
    logic [1:0]    h_size;
    logic [3:0]    h_off;
    logic [4:0]    h_n;
    logic          h_cross;
    logic [255:0]  h_wide;
    logic [31:0]   h_wmask;

    assign wbaq_full  = (count_q == CW'(DEPTH));
    assign wbaq_empty = (count_q == '0);

    // Head entry decode. The store is laid out over a two-line window: the low
    // 128 bits / 16 mask bits feed FIRST, the high half feeds SECOND.
    always_comb begin
        h_addr  = addr_q[head_q];
        h_data  = data_q[head_q];
        h_size  = size_q[head_q];
        h_off   = h_addr[3:0];
        h_n     = 5'd1 << h_size;
        h_cross = ({1'b0, h_off} + h_n) > 5'd16;
        h_dm    = '0;
        for (int b = 0; b < 8; b++)
            if (5'(b) < h_n) h_dm[8*b +: 8] = h_data[8*b +: 8];
        h_wide  = {192'b0, h_dm} << {h_off, 3'b000};
        h_wmask = ((32'd1 << h_n) - 32'd1) << h_off;
    end

    // Moore request outputs: decoded from state and head entry only.
    always_comb begin
        dc_req_valid = 1'b0;
        dc_req_line  = '0;
        dc_req_mask  = '0;
        dc_req_data  = '0;
        if (state_q == FIRST) begin
            dc_req_valid = 1'b1;
            dc_req_line  = h_addr[31:4];
            dc_req_mask  = h_wmask[15:0];
            dc_req_data  = h_wide[127:0];
        end else if (state_q == SECOND) begin
            dc_req_valid = 1'b1;
            dc_req_line  = h_addr[31:4] + 28'd1;
            dc_req_mask  = h_wmask[31:16];
            dc_req_data  = h_wide[255:128];
        end
    end

    always_comb begin
        push    = mem_ld & ~wbaq_full;
        pop     = dc_req_ready & (((state_q == FIRST) & ~h_cross) | (state_q == SECOND));
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        if (push) begin
            addr_d[tail_q] = mem_addr;
            data_d[tail_q] = mem_data;
            size_d[tail_q] = memsize;
        end
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        head_d  = pop  ? head_q + PW'(1) : head_q;
        count_d = count_q + CW'(push) - CW'(pop);

        state_d = state_q;
        case (state_q)
            IDLE:   if (count_q != '0) state_d = FIRST;
            FIRST:  if (dc_req_ready) begin
                        if (h_cross)              state_d = SECOND;
                        else if (count_d == '0)   state_d = IDLE;
                    end
            SECOND: if (dc_req_ready) state_d = (count_d == '0) ? IDLE : FIRST;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Payload storage needs no reset: validity comes from head/count.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        size_q <= size_d;
    end

`ifdef WBAQ_LD_CONFLICT_EN
    logic [DEPTH-1:0] hit;
    for (genvar i = 0; i < DEPTH; i++) begin : g_chk
        logic [PW-1:0] rel;
        logic          vld, cr;
        logic [27:0]   ln;
        always_comb begin
            rel    = PW'(i) - head_q;
            vld    = {1'b0, rel} < count_q;
            ln     = addr_q[i][31:4];
            cr     = ({1'b0, addr_q[i][3:0]} + (5'd1 << size_q[i])) > 5'd16;
            hit[i] = vld & ((ln == ld_chk_addr[31:4]) |
                            (cr & ((ln + 28'd1) == ld_chk_addr[31:4])));
        end
    end
    assign ld_conflict = |hit;
`else
    logic unused_chk;
    assign unused_chk  = ^ld_chk_addr;
    assign ld_conflict = 1'b0;
`endif

endmodule

// File: doc/wbaq_store_drain.md
# wbaq_store_drain

Write-back address queue (WBAQ) that sits between the writeback stage and the data cache write port. It accepts one committed memory write per cycle from writeback (`mem_ld`, `mem_addr`, `mem_data`, `memsize`) and raises `wbaq_full` as writeback's back-pressure. It drains entries in order to the cache as 16-byte-line, byte-masked write requests over a valid/ready handshake. Stores that cross a line boundary are split into two line requests.

## Interface
- `DEPTH`, 8 — number of queue entries; power of two, 2..16.
- `clk` input 1 — sole clock; all state updates on rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `mem_ld` input 1 — enqueue request from writeback (already valid-qualified).
- `mem_addr` input 32 — byte address of store.
- `mem_data` input 64 — store data, little-endian, LSB byte at `mem_addr`.
- `memsize` input 2 — 00=1B, 01=2B, 10=4B, 11=8B.
- `wbaq_full` output 1 — queue holds DEPTH entries.
- `wbaq_empty` output 1 — queue holds 0 entries.
- `dc_req_valid` output 1 — line write request valid.
- `dc_req_ready` input 1 — cache accepts request this cycle.
- `dc_req_line` output 28 — line address (addr[31:4]).
- `dc_req_mask` output 16 — byte enables within line.
- `dc_req_data` output 128 — line-positioned data; unmasked bytes are 0.
- `ld_chk_addr` input 32 — load address for conflict check (macro-dependent).
- `ld_conflict` output 1 — some queued store touches the same line as `ld_chk_addr` (macro-dependent).

## Operation
- Storage: circular buffer of DEPTH entries {addr[31:0], data[63:0], size[1:0]}, head/tail pointers, occupancy count (log2(DEPTH)+1 bits).
- Enqueue: when `mem_ld`=1 and `wbaq_full`=0, write at tail, tail+1 mod DEPTH, count+1. When `mem_ld`=1 and `wbaq_full`=1, the write is dropped; writeback holds it via its own stall.
- Full is judged on the registered count only: a pop in the same cycle does not allow an enqueue while full.
- Simultaneous accepted enqueue and entry retirement leaves count unchanged.
- Head decode: n = 1<<size; off = addr[3:0]; cross = (off+n > 16).
- Drain FSM:
  - IDLE: `dc_req_valid`=0. If count>0, go to FIRST.
  - FIRST: present head. line = addr[31:4]; mask = ((1<<n)-1)<<off truncated to 16 bits; data = data<<(8·off) truncated to 128 bits.
    - On ready with cross=0: retire head and go to IDLE if the count after retirement is 0, else stay in FIRST.
    - On ready with cross=1: go to SECOND.
  - SECOND: line = addr[31:4]+1 (wraps mod 2^28); mask = (1<<(off+n−16))−1; data = data>>(8·(16−off)). On ready, retire head, then behave as in FIRST.
- Request fields stay stable while `dc_req_valid`=1 and `dc_req_ready`=0.
- Retire: head+1 mod DEPTH, count−1. Entries are never cancelled, because all writes are committed.

## Timing
- Reset: count=0, head=tail=0, FSM=IDLE. Outputs: `wbaq_full`=0, `wbaq_empty`=1, `dc_req_valid`=0, line/mask/data=0, `ld_conflict`=0.
- Reset mid-drain discards all entries, including a half-sent split store.
- Enqueue-to-request latency: 2 cycles into an empty queue (cycle 0 write, cycle 1 IDLE→FIRST, cycle 2 `dc_req_valid`).
- Back-to-back drain: 1 request per cycle while ready=1. A split store occupies 2 consecutive request cycles.
- `wbaq_full` and `wbaq_empty` are decoded from the registered count, with no combinational path from `mem_ld`.
- `dc_req_*` outputs depend only on registered state (Moore). There is no combinational ready→valid path.

## Configuration
- Macro `WBAQ_LD_CONFLICT_EN`.
- With the macro defined: `ld_conflict` = OR over valid entries of (entry addr[31:4] == ld_chk_addr[31:4]). For crossing entries, also OR in (entry addr[31:4]+1 == ld_chk_addr[31:4]). The result is combinational from `ld_chk_addr` and the registered entries. An entry retiring this cycle still counts.
- Without the macro: `ld_conflict` tied to 0, `ld_chk_addr` unused, and no comparators are built.

## Test plan
- Reset then single store: addr=0x1004, data=0xAABBCCDD, size=10, ready=1 → 2 cycles later line=0x100, mask=0x00F0, data bytes 4..7=DD,CC,BB,AA. Then empty=1.
- Split store: addr=0x200E, size=10, data=0x11223344 → FIRST: line=0x200, mask=0xC000, bytes 14,15=44,33. SECOND: line=0x201, mask=0x0003, bytes 0,1=22,11.
- Fill with ready=0: 8 enqueues → `wbaq_full`=1 and the 9th `mem_ld` is dropped. Raise ready → 8 requests in FIFO order, then empty.
- Full plus pop in the same cycle with `mem_ld`=1 → no enqueue; count goes 8→7 and full deasserts the next cycle.
- Stall stability: ready=0 for 5 cycles → line, mask and data unchanged. Assert rst in the middle of a SECOND beat → next cycle valid=0, empty=1.
- With `WBAQ_LD_CONFLICT_EN`: queue addr=0x300F size=01 → `ld_chk_addr`=0x3010 gives conflict=1, 0x3020 gives conflict=0. Without the macro: conflict=0 always.
